// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection constants and receiver state encoding.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with selectable reset level.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start-edge detect, glitch rejection, centre sampling,
// optional parity, 1 or 2 stop bits, valid/ready output register with error pulses.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic rx_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    rx_state_t            state, state_nxt;
    logic [TW-1:0]        tick_ctr, tick_ctr_nxt;
    logic [BW-1:0]        bit_ctr, bit_ctr_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_bad, par_bad_nxt;
    logic                 frm_bad, frm_bad_nxt;
    logic                 rx_prev, rx_prev_nxt;
    logic [DATA_BITS-1:0] dout_nxt;
    logic                 dout_vld_nxt;
    logic                 parity_err_nxt, frame_err_nxt, overrun_nxt;
    logic                 frm_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            tick_ctr   <= '0;
            bit_ctr    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            frm_bad    <= 1'b0;
            rx_prev    <= 1'b1;
            dout       <= '0;
            dout_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_ctr   <= tick_ctr_nxt;
            bit_ctr    <= bit_ctr_nxt;
            shreg      <= shreg_nxt;
            par_bad    <= par_bad_nxt;
            frm_bad    <= frm_bad_nxt;
            rx_prev    <= rx_prev_nxt;
            dout       <= dout_nxt;
            dout_vld   <= dout_vld_nxt;
            parity_err <= parity_err_nxt;
            frame_err  <= frame_err_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tick_ctr_nxt   = tick_ctr;
        bit_ctr_nxt    = bit_ctr;
        shreg_nxt      = shreg;
        par_bad_nxt    = par_bad;
        frm_bad_nxt    = frm_bad;
        rx_prev_nxt    = rx_prev;
        dout_nxt       = dout;
        dout_vld_nxt   = dout_vld & ~dout_rdy;
        parity_err_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        overrun_nxt    = 1'b0;
        frm_now        = 1'b0;

        if (tick) begin
            // rx_prev follows every tick, so the STOP->IDLE return sees the stop sample
            rx_prev_nxt  = rx_s;
            tick_ctr_nxt = tick_ctr + 1'b1;
            case (state)
                RX_IDLE: begin
                    tick_ctr_nxt = '0;
                    if (rx_prev && !rx_s) begin
                        state_nxt   = RX_START;
                        bit_ctr_nxt = '0;
                        par_bad_nxt = 1'b0;
                        frm_bad_nxt = 1'b0;
                    end
                end
                RX_START: begin
                    if (tick_ctr == HALF_M1) begin
                        tick_ctr_nxt = '0;
                        state_nxt    = rx_s ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (tick_ctr == FULL_M1) begin
                        tick_ctr_nxt = '0;
                        shreg_nxt    = {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_ctr == LAST_DATA) begin
                            bit_ctr_nxt = '0;
                            state_nxt   = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_ctr_nxt = bit_ctr + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick_ctr == FULL_M1) begin
                        tick_ctr_nxt = '0;
                        par_bad_nxt  = (PARITY == PAR_ODD) ? ~(^shreg ^ rx_s) : (^shreg ^ rx_s);
                        state_nxt    = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (tick_ctr == FULL_M1) begin
                        tick_ctr_nxt = '0;
                        frm_now      = frm_bad | ~rx_s;
                        if (bit_ctr == LAST_STOP) begin
                            state_nxt   = RX_IDLE;
                            bit_ctr_nxt = '0;
                            if (frm_now) begin
                                frame_err_nxt = 1'b1;
                            end else if (par_bad) begin
                                parity_err_nxt = 1'b1;
                            end else if (!dout_vld || dout_rdy) begin
                                dout_nxt     = shreg;
                                dout_vld_nxt = 1'b1;
                            end else begin
                                overrun_nxt = 1'b1;
                            end
                        end else begin
                            frm_bad_nxt = frm_now;
                            bit_ctr_nxt = bit_ctr + 1'b1;
                        end
                    end
                end
                default: state_nxt = RX_IDLE;
            endcase
        end
    end

endmodule
